// File: rtl/issue_pkg.sv
// +--------------------------------------------------------------------+
// | issue_pkg: shared state type and forwarding-select codes for the  |
// |            dual-issue controller.                                  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package issue_pkg;

    typedef enum logic [0:0] {
        PAIR  = 1'b0,
        HOLD2 = 1'b1
    } state_t;

    // Lane-1 operand mux codes
    localparam logic [2:0] FWD1_RF    = 3'd0;
    localparam logic [2:0] FWD1_RESW  = 3'd1;
    localparam logic [2:0] FWD1_ALUM  = 3'd2;
    localparam logic [2:0] FWD1_ALUM2 = 3'd3;
    localparam logic [2:0] FWD1_RESW2 = 3'd4;

    // Lane-2 operand mux codes
    localparam logic [2:0] FWD2_RF    = 3'd0;
    localparam logic [2:0] FWD2_RESW2 = 3'd1;
    localparam logic [2:0] FWD2_ALUM2 = 3'd2;
    localparam logic [2:0] FWD2_CHAIN = 3'd3;
    localparam logic [2:0] FWD2_ALUM  = 3'd4;
    localparam logic [2:0] FWD2_RESW  = 3'd5;

endpackage

`default_nettype wire

// File: rtl/dual_issue_ctrl_fwd_sel.sv
// +--------------------------------------------------------------------+
// | fwd_sel: combinational priority matcher for one ALU operand.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module fwd_sel
    import issue_pkg::*;
#(
    parameter int LANE  = 1,
    parameter int REG_W = 5,
    parameter int SEL_W = 3
) (
    input  logic [REG_W-1:0] src,
    input  logic [REG_W-1:0] d_wr1,
    input  logic             d_we1,
    input  logic [REG_W-1:0] e_wr1,
    input  logic             e_we1,
    input  logic [REG_W-1:0] e_wr2,
    input  logic             e_we2,
    input  logic [REG_W-1:0] m_wr1,
    input  logic             m_we1,
    input  logic [REG_W-1:0] m_wr2,
    input  logic             m_we2,
    output logic [SEL_W-1:0] sel
);

    logic nz;
    assign nz = (src != '0);

    generate
        if (LANE == 2) begin : g_lane2
            // The same-cycle lane-1 result is the youngest producer of all
            always_comb begin
                sel = SEL_W'(FWD2_RF);
                if      (nz && d_we1 && src == d_wr1) sel = SEL_W'(FWD2_CHAIN);
                else if (nz && e_we2 && src == e_wr2) sel = SEL_W'(FWD2_ALUM2);
                else if (nz && e_we1 && src == e_wr1) sel = SEL_W'(FWD2_ALUM);
                else if (nz && m_we2 && src == m_wr2) sel = SEL_W'(FWD2_RESW2);
                else if (nz && m_we1 && src == m_wr1) sel = SEL_W'(FWD2_RESW);
            end
        end else begin : g_lane1
            logic unused_d;
            assign unused_d = ^{d_wr1, d_we1};

            always_comb begin
                sel = SEL_W'(FWD1_RF);
                if      (nz && e_we2 && src == e_wr2) sel = SEL_W'(FWD1_ALUM2);
                else if (nz && e_we1 && src == e_wr1) sel = SEL_W'(FWD1_ALUM);
                else if (nz && m_we2 && src == m_wr2) sel = SEL_W'(FWD1_RESW2);
                else if (nz && m_we1 && src == m_wr1) sel = SEL_W'(FWD1_RESW);
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/dual_issue_ctrl.sv
// +--------------------------------------------------------------------+
// | dual_issue_ctrl: issue/hazard control and forwarding selects for  |
// | the dual-issue execute stage. Option macro: DUAL_ISSUE_CHAIN_EN.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module dual_issue_ctrl
    import issue_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_valid,
    input  logic [REG_W-1:0] d_rs1,
    input  logic [REG_W-1:0] d_rt1,
    input  logic [REG_W-1:0] d_rs2,
    input  logic [REG_W-1:0] d_rt2,
    input  logic [REG_W-1:0] d_wr1,
    input  logic [REG_W-1:0] d_wr2,
    input  logic             d_we1,
    input  logic             d_we2,
    input  logic             d_ld1,
    input  logic             d_ld2,
    input  logic [REG_W-1:0] e_wr1,
    input  logic [REG_W-1:0] e_wr2,
    input  logic             e_we1,
    input  logic             e_we2,
    input  logic             e_ld1,
    input  logic             e_ld2,
    input  logic [REG_W-1:0] m_wr1,
    input  logic [REG_W-1:0] m_wr2,
    input  logic             m_we1,
    input  logic             m_we2,
    input  logic             flush,
    output logic             stall_d,
    output logic             iss_v1,
    output logic             iss_v2,
    output logic [SEL_W-1:0] fwd_a1,
    output logic [SEL_W-1:0] fwd_b1,
    output logic [SEL_W-1:0] fwd_a2,
    output logic [SEL_W-1:0] fwd_b2
);

    state_t           state, state_nx;
    logic [REG_W-1:0] hold_rs, hold_rt;
    logic [REG_W-1:0] src2_a, src2_b;
    logic             lu1, lu2, reads_wr1, split, chain_we;
    logic             nx_v1, nx_v2, capture;
    logic [SEL_W-1:0] sel_a1, sel_b1, sel_a2, sel_b2;

    // Lane-2 destination/load flags never affect issue decisions
    logic unused_lane2;
    assign unused_lane2 = ^{d_wr2, d_we2, d_ld2};

    function automatic logic ld_hit(input logic [REG_W-1:0] s,
                                    input logic [REG_W-1:0] wr1, input logic hit1,
                                    input logic [REG_W-1:0] wr2, input logic hit2);
        return (s != '0) && ((hit1 && s == wr1) || (hit2 && s == wr2));
    endfunction

    assign src2_a = (state == HOLD2) ? hold_rs : d_rs2;
    assign src2_b = (state == HOLD2) ? hold_rt : d_rt2;

    assign lu1 = ld_hit(d_rs1, e_wr1, e_we1 & e_ld1, e_wr2, e_we2 & e_ld2)
               | ld_hit(d_rt1, e_wr1, e_we1 & e_ld1, e_wr2, e_we2 & e_ld2);
    assign lu2 = ld_hit(src2_a, e_wr1, e_we1 & e_ld1, e_wr2, e_we2 & e_ld2)
               | ld_hit(src2_b, e_wr1, e_we1 & e_ld1, e_wr2, e_we2 & e_ld2);

    assign reads_wr1 = d_we1 && (d_wr1 != '0) && (d_rs2 == d_wr1 || d_rt2 == d_wr1);

`ifdef DUAL_ISSUE_CHAIN_EN
    assign split    = reads_wr1 && d_ld1;
    assign chain_we = d_we1 && (state == PAIR);
`else
    assign split    = reads_wr1;
    assign chain_we = 1'b0;
`endif

    fwd_sel #(.LANE(1), .REG_W(REG_W), .SEL_W(SEL_W)) u_sel_a1 (
        .src(d_rs1), .d_wr1(d_wr1), .d_we1(1'b0),
        .e_wr1(e_wr1), .e_we1(e_we1), .e_wr2(e_wr2), .e_we2(e_we2),
        .m_wr1(m_wr1), .m_we1(m_we1), .m_wr2(m_wr2), .m_we2(m_we2), .sel(sel_a1));
    fwd_sel #(.LANE(1), .REG_W(REG_W), .SEL_W(SEL_W)) u_sel_b1 (
        .src(d_rt1), .d_wr1(d_wr1), .d_we1(1'b0),
        .e_wr1(e_wr1), .e_we1(e_we1), .e_wr2(e_wr2), .e_we2(e_we2),
        .m_wr1(m_wr1), .m_we1(m_we1), .m_wr2(m_wr2), .m_we2(m_we2), .sel(sel_b1));
    fwd_sel #(.LANE(2), .REG_W(REG_W), .SEL_W(SEL_W)) u_sel_a2 (
        .src(src2_a), .d_wr1(d_wr1), .d_we1(chain_we),
        .e_wr1(e_wr1), .e_we1(e_we1), .e_wr2(e_wr2), .e_we2(e_we2),
        .m_wr1(m_wr1), .m_we1(m_we1), .m_wr2(m_wr2), .m_we2(m_we2), .sel(sel_a2));
    fwd_sel #(.LANE(2), .REG_W(REG_W), .SEL_W(SEL_W)) u_sel_b2 (
        .src(src2_b), .d_wr1(d_wr1), .d_we1(chain_we),
        .e_wr1(e_wr1), .e_we1(e_we1), .e_wr2(e_wr2), .e_we2(e_we2),
        .m_wr1(m_wr1), .m_we1(m_we1), .m_wr2(m_wr2), .m_we2(m_we2), .sel(sel_b2));

    always_comb begin
        state_nx = state;
        stall_d  = 1'b0;
        nx_v1    = 1'b0;
        nx_v2    = 1'b0;
        capture  = 1'b0;
        if (flush) begin
            state_nx = PAIR;
        end else begin
            case (state)
                PAIR: begin
                    if (d_valid) begin
                        if (lu1 || lu2) begin
                            stall_d = 1'b1;
                        end else if (split) begin
                            nx_v1    = 1'b1;
                            stall_d  = 1'b1;
                            capture  = 1'b1;
                            state_nx = HOLD2;
                        end else begin
                            nx_v1 = 1'b1;
                            nx_v2 = 1'b1;
                        end
                    end
                end
                HOLD2: begin
                    // D keeps the original pair until the held half issues
                    if (lu2) begin
                        stall_d = 1'b1;
                    end else begin
                        nx_v2    = 1'b1;
                        state_nx = PAIR;
                    end
                end
                default: state_nx = PAIR;
            endcase
        end
        if (rst) stall_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= PAIR;
            iss_v1  <= 1'b0;
            iss_v2  <= 1'b0;
            fwd_a1  <= '0;
            fwd_b1  <= '0;
            fwd_a2  <= '0;
            fwd_b2  <= '0;
            hold_rs <= '0;
            hold_rt <= '0;
        end else begin
            state  <= state_nx;
            iss_v1 <= nx_v1;
            iss_v2 <= nx_v2;
            fwd_a1 <= nx_v1 ? sel_a1 : '0;
            fwd_b1 <= nx_v1 ? sel_b1 : '0;
            fwd_a2 <= nx_v2 ? sel_a2 : '0;
            fwd_b2 <= nx_v2 ? sel_b2 : '0;
            if (flush) begin
                hold_rs <= '0;
                hold_rt <= '0;
            end else if (capture) begin
                hold_rs <= d_rs2;
                hold_rt <= d_rt2;
            end
        end
    end

endmodule

`default_nettype wire
